// File: rtl/msx_slot_initiator.sv
`default_nettype none
// ============================================================================
//  Module      : msx_slot_initiator
//  Description : Host-side MSX cartridge slot bus initiator. Turns a single
//                valid/ready request into a timed memory or I/O bus cycle.
//                The cycle runs address setup, then a strobe that the
//                cartridge may stretch with WAIT, then an address/data hold.
//                A bounded wait timeout aborts cycles that would never end.
//  Revision    : 1.0 - initial release
// ============================================================================
module msx_slot_initiator #(
    parameter int ADDR_SETUP   = 2,
    parameter int STROBE_LEN   = 4,
    parameter int HOLD_LEN     = 1,
    parameter int WAIT_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic        req_io,
    input  logic [15:0] req_address,
    input  logic [7:0]  req_wdata,
    output logic        resp_valid,
    output logic [7:0]  resp_rdata,
    output logic        resp_timeout,
    output logic [15:0] slot_a,
    input  logic [7:0]  slot_d_in,
    output logic [7:0]  slot_d_out,
    output logic        slot_d_oe,
    output logic        slot_sltsl,
    output logic        slot_mereq_n,
    output logic        slot_ioreq_n,
    output logic        slot_rd_n,
    output logic        slot_wr_n,
    input  logic        slot_wait
);

    // Terminal counts: each phase counter runs 0 .. LEN-1.
    localparam logic [9:0] c_SETUP_LAST  = 10'(ADDR_SETUP - 1);
    localparam logic [9:0] c_STROBE_LAST = 10'(STROBE_LEN - 1);
    localparam logic [9:0] c_HOLD_LAST   = 10'(HOLD_LEN - 1);
    localparam logic [9:0] c_WAIT_LAST   = 10'(WAIT_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SETUP  = 3'd1,
        S_STROBE = 3'd2,
        S_EXTEND = 3'd3,
        S_HOLD   = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [9:0]  r_cnt;
    logic [9:0]  w_cnt_next;
    logic        r_write;
    logic        r_io;
    logic        w_accept;
    logic        w_end_ok;
    logic        w_abort;
    logic        w_hold_done;
    logic        w_strobe_on;

    assign req_ready = (r_state == S_IDLE);

    // Strobes are low exactly while the FSM sits in STROBE or EXTEND.
    assign w_strobe_on = (w_state_next == S_STROBE) || (w_state_next == S_EXTEND);

    // State and phase counter register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Next-state logic and the cycle events that steer the datapath.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_accept     = 1'b0;
        w_end_ok     = 1'b0;
        w_abort      = 1'b0;
        w_hold_done  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    w_accept     = 1'b1;
                    w_state_next = S_SETUP;
                    w_cnt_next   = '0;
                end
            end
            S_SETUP: begin
                if (r_cnt == c_SETUP_LAST) begin
                    w_state_next = S_STROBE;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next = r_cnt + 10'd1;
                end
            end
            S_STROBE: begin
                // WAIT only matters on the final strobe clock.
                if (r_cnt == c_STROBE_LAST) begin
                    w_cnt_next = '0;
                    if (slot_wait) begin
                        w_state_next = S_EXTEND;
                    end else begin
                        w_state_next = S_HOLD;
                        w_end_ok     = 1'b1;
                    end
                end else begin
                    w_cnt_next = r_cnt + 10'd1;
                end
            end
            S_EXTEND: begin
                // A released WAIT wins over a simultaneous timeout.
                w_cnt_next = '0;
                if (!slot_wait) begin
                    w_state_next = S_HOLD;
                    w_end_ok     = 1'b1;
                end else if (r_cnt == c_WAIT_LAST) begin
                    w_state_next = S_HOLD;
                    w_abort      = 1'b1;
                end else begin
                    w_cnt_next = r_cnt + 10'd1;
                end
            end
            S_HOLD: begin
                if (r_cnt == c_HOLD_LAST) begin
                    w_state_next = S_IDLE;
                    w_hold_done  = 1'b1;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next = r_cnt + 10'd1;
                end
            end
            default: begin
                w_state_next = S_IDLE;
                w_cnt_next   = '0;
            end
        endcase
    end

    // Registered bus outputs, request latches and response data.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_write      <= 1'b0;
            r_io         <= 1'b0;
            slot_a       <= '0;
            slot_d_out   <= '0;
            slot_d_oe    <= 1'b0;
            slot_sltsl   <= 1'b0;
            slot_mereq_n <= 1'b1;
            slot_ioreq_n <= 1'b1;
            slot_rd_n    <= 1'b1;
            slot_wr_n    <= 1'b1;
            resp_valid   <= 1'b0;
            resp_rdata   <= '0;
            resp_timeout <= 1'b0;
        end else begin
            resp_valid <= w_hold_done;

            slot_mereq_n <= !(w_strobe_on && !r_io);
            slot_ioreq_n <= !(w_strobe_on &&  r_io);
            slot_rd_n    <= !(w_strobe_on && !r_write);
            slot_wr_n    <= !(w_strobe_on &&  r_write);

            if (w_accept) begin
                r_write    <= req_write;
                r_io       <= req_io;
                slot_a     <= req_address;
                slot_sltsl <= !req_io;
                slot_d_oe  <= req_write;
                if (req_write) begin
                    slot_d_out <= req_wdata;
                end
            end

            if (w_end_ok) begin
                resp_rdata   <= r_write ? 8'h00 : slot_d_in;
                resp_timeout <= 1'b0;
            end

            if (w_abort) begin
                resp_rdata   <= 8'hFF;
                resp_timeout <= 1'b1;
            end

            // slot_a and slot_d_out keep their values once the cycle ends.
            if (w_hold_done) begin
                slot_sltsl <= 1'b0;
                slot_d_oe  <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_msx_slot_initiator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_msx_slot_initiator
//  Description : Directed self-checking bench for msx_slot_initiator with a
//                response scoreboard and per-clock bus waveform checks.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_msx_slot_initiator;

    localparam int AS = 2;
    localparam int SL = 4;
    localparam int HL = 1;
    localparam int WT = 255;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic        req_io;
    logic [15:0] req_address;
    logic [7:0]  req_wdata;
    logic        resp_valid;
    logic [7:0]  resp_rdata;
    logic        resp_timeout;
    logic [15:0] slot_a;
    logic [7:0]  slot_d_in;
    logic [7:0]  slot_d_out;
    logic        slot_d_oe;
    logic        slot_sltsl;
    logic        slot_mereq_n;
    logic        slot_ioreq_n;
    logic        slot_rd_n;
    logic        slot_wr_n;
    logic        slot_wait;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    typedef struct {
        logic [7:0] rdata;
        logic       timeout;
        int         accept_edge;
        int         lat;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    msx_slot_initiator #(
        .ADDR_SETUP  (AS),
        .STROBE_LEN  (SL),
        .HOLD_LEN    (HL),
        .WAIT_TIMEOUT(WT)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_write   (req_write),
        .req_io      (req_io),
        .req_address (req_address),
        .req_wdata   (req_wdata),
        .resp_valid  (resp_valid),
        .resp_rdata  (resp_rdata),
        .resp_timeout(resp_timeout),
        .slot_a      (slot_a),
        .slot_d_in   (slot_d_in),
        .slot_d_out  (slot_d_out),
        .slot_d_oe   (slot_d_oe),
        .slot_sltsl  (slot_sltsl),
        .slot_mereq_n(slot_mereq_n),
        .slot_ioreq_n(slot_ioreq_n),
        .slot_rd_n   (slot_rd_n),
        .slot_wr_n   (slot_wr_n),
        .slot_wait   (slot_wait)
    );

    always #5 clk = ~clk;

    // Rising-edge counter used to time responses from the accepting edge.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Strobe exclusivity every clock; scoreboard pop on every response.
    always @(negedge clk) begin
        check("strobe_excl",
              64'({(!slot_mereq_n && !slot_ioreq_n), (!slot_rd_n && !slot_wr_n)}), 64'd0);
        if (resp_valid) begin
            check("resp_expected", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                check("resp_rdata",   64'(resp_rdata),   64'(mon_e.rdata));
                check("resp_timeout", 64'(resp_timeout), 64'(mon_e.timeout));
                check("resp_latency", 64'(cyc - mon_e.accept_edge), 64'(mon_e.lat));
            end
        end
    end

    // One complete bus cycle. Called and returns on a falling edge.
    // ext = extra strobe clocks; WAIT is held high everywhere except the
    // edge that should end the strobe, so it is ignored in all other phases.
    task automatic run(input logic wr, input logic io, input logic [15:0] addr,
                       input logic [7:0] wd, input logic [7:0] din, input int ext,
                       input logic to, input logic keep);
        int         b;
        int         n;
        int         kend;
        logic       sl;
        logic       act;
        logic [6:0] exp_bus;
        logic [7:0] exp_rd;
        req_write   = wr;
        req_io      = io;
        req_address = addr;
        req_wdata   = wd;
        req_valid   = 1'b1;
        slot_wait   = 1'b1;
        slot_d_in   = 8'hEE;
        b = 0;
        while (!req_ready && b < 50) begin
            @(negedge clk);
            b++;
        end
        check("req_ready_wait", 64'(req_ready), 64'd1);
        if (!req_ready) begin
            req_valid = 1'b0;
            return;
        end
        n      = cyc + 1;
        kend   = AS + SL + ext + HL;
        exp_rd = to ? 8'hFF : (wr ? 8'h00 : din);
        sb.push_back('{exp_rd, to, n, kend});
        for (int k = 0; k <= kend; k++) begin
            @(negedge clk);
            if (k == 0 && !keep) req_valid = 1'b0;
            sl  = (k >= AS) && (k <= AS + SL + ext - 1);
            act = (k < kend);
            exp_bus = {!(sl && !io), !(sl && io), !(sl && !wr), !(sl && wr),
                       act && !io, act && wr, k == kend};
            check("bus_ctrl",
                  64'({slot_mereq_n, slot_ioreq_n, slot_rd_n, slot_wr_n,
                       slot_sltsl, slot_d_oe, req_ready}), 64'(exp_bus));
            check("addr_data", 64'({slot_a, (wr ? slot_d_out : 8'h00)}),
                  64'({addr, (wr ? wd : 8'h00)}));
            slot_wait = to ? 1'b1 : ((k + 1) != AS + SL + ext);
            slot_d_in = ((k + 1) == AS + SL + ext) ? din : 8'hEE;
        end
        slot_wait = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n     = 1'b0;
        req_valid   = 1'b0;
        req_write   = 1'b0;
        req_io      = 1'b0;
        req_address = '0;
        req_wdata   = '0;
        slot_d_in   = '0;
        slot_wait   = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_state",
              64'({req_ready, resp_valid, resp_timeout, resp_rdata, slot_a, slot_d_out,
                   slot_d_oe, slot_sltsl, slot_mereq_n, slot_ioreq_n, slot_rd_n, slot_wr_n}),
              64'({1'b1, 1'b0, 1'b0, 8'h00, 16'h0000, 8'h00, 1'b0, 1'b0, 4'hF}));
        reset_n = 1'b1;
        @(negedge clk);

        // Memory write, no wait.
        run(1'b1, 1'b0, 16'h4000, 8'h5A, 8'h00, 0, 1'b0, 1'b0);
        // I/O read.
        run(1'b0, 1'b1, 16'h00A0, 8'h00, 8'h3C, 0, 1'b0, 1'b0);
        // Memory read stretched by 10 wait clocks.
        run(1'b0, 1'b0, 16'h8123, 8'h00, 8'hA7, 10, 1'b0, 1'b0);
        // Wait stuck high: timeout abort.
        run(1'b0, 1'b0, 16'hBEEF, 8'h00, 8'h42, WT, 1'b1, 1'b0);

        // Back-to-back with req_valid held high.
        run(1'b1, 1'b1, 16'h0011, 8'h77, 8'h00, 0, 1'b0, 1'b1);
        check("b2b_resp_ready", 64'({resp_valid, req_ready}), 64'd3);
        run(1'b0, 1'b0, 16'h1234, 8'h00, 8'h99, 0, 1'b0, 1'b0);

        // Reset pulsed during the strobe.
        req_write   = 1'b1;
        req_io      = 1'b0;
        req_address = 16'h2222;
        req_wdata   = 8'h11;
        req_valid   = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("pre_reset_strobe", 64'({slot_mereq_n, slot_wr_n}), 64'd0);
        #2 reset_n = 1'b0;
        #1;
        check("mid_reset_state",
              64'({req_ready, resp_valid, resp_timeout, resp_rdata, slot_a, slot_d_out,
                   slot_d_oe, slot_sltsl, slot_mereq_n, slot_ioreq_n, slot_rd_n, slot_wr_n}),
              64'({1'b1, 1'b0, 1'b0, 8'h00, 16'h0000, 8'h00, 1'b0, 1'b0, 4'hF}));
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check("post_reset_quiet",
                  64'({resp_valid, slot_sltsl, slot_mereq_n, slot_ioreq_n, slot_rd_n, slot_wr_n}),
                  64'({1'b0, 1'b0, 4'hF}));
        end

        // Normal cycle after recovery.
        run(1'b1, 1'b0, 16'hFFFF, 8'hC3, 8'h00, 0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        check("scoreboard_empty", 64'(sb.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
